// File: rtl/input_transform_stream_pkg.sv
// Shared types for the isomorphism-transform datapath.
//   mm_matrix_t : 8x8 GF(2) matrix, row r = m[r], column c = m[r][c]
//   MM_IDENTITY : identity matrix (reset value of every matrix register)
//   it_state_t  : control states of input_transform_stream
package input_transform_stream_pkg;

  typedef logic [7:0][7:0] mm_matrix_t;

  // Row r has only bit r set.
  localparam mm_matrix_t MM_IDENTITY = 64'h8040_2010_0804_0201;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } it_state_t;

endpackage : input_transform_stream_pkg

// File: rtl/input_transform_stream_matrix_mul.sv
// matrix_mul: combinational 8x8 GF(2) matrix-vector product.
//   Parameter D : 0 -> out = M * in, 1 -> out = M^T * in
//   m_i         : matrix
//   in_i        : input vector, element c = in_i[c]
//   out_o       : output vector, element r = out_o[r]
module matrix_mul
  import input_transform_stream_pkg::*;
#(
  parameter bit D = 1'b0
) (
  input  mm_matrix_t  m_i,
  input  logic [7:0]  in_i,
  output logic [7:0]  out_o
);

  always_comb begin
    // NOTE: assign a default before any conditional/accumulating update so
    // no path leaves the output unassigned (which would infer a latch).
    out_o = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        out_o[r] ^= (D ? m_i[c][r] : m_i[r][c]) & in_i[c];
      end
    end
  end

endmodule : matrix_mul

// File: rtl/input_transform_stream.sv
// input_transform_stream: handshaked block transform. Every byte of a
// BLOCK_BYTES block is multiplied by a run-time-loaded GF(2) matrix L,
// LANES bytes per cycle, with an optional register stage (PIPE).
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   mat_load, mat_in  load L (honoured in IDLE only)
//   in_valid/in_ready/in_block     input block handshake
//   out_valid/out_ready/out_block  output block handshake
//   busy              high whenever the control FSM is not IDLE
//
// Optional feature macro INPUT_TRANSFORM_STREAM_INV_EN adds mat_inv_load,
// mat_inv_in and dir: a second (inverse) matrix register and a per-block
// direction select latched at acceptance.
module input_transform_stream
  import input_transform_stream_pkg::*;
#(
  parameter int BLOCK_BYTES = 16,
  parameter int LANES       = 4,
  parameter int PIPE        = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mat_load,
  input  mm_matrix_t               mat_in,
`ifdef INPUT_TRANSFORM_STREAM_INV_EN
  input  logic                     mat_inv_load,
  input  mm_matrix_t               mat_inv_in,
  input  logic                     dir,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*BLOCK_BYTES-1:0] in_block,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*BLOCK_BYTES-1:0] out_block,
  output logic                     busy
);

  localparam int BEATS = BLOCK_BYTES / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  it_state_t                  state_q, state_d;
  logic [BW-1:0]              beat_q;
  mm_matrix_t                 mat_q;
  mm_matrix_t                 sel_mat;
  logic [8*BLOCK_BYTES-1:0]   in_q;
  logic [8*BLOCK_BYTES-1:0]   out_q;
  logic                       accept;
  logic                       load_any;
  logic [LANES-1:0][7:0]      res_w;

  logic                       wr_en;
  logic [BW-1:0]              wr_beat;
  logic [LANES-1:0][7:0]      wr_data;

  assign accept = in_valid && in_ready;

`ifdef INPUT_TRANSFORM_STREAM_INV_EN
  mm_matrix_t mat_inv_q;
  logic       dir_q;

  assign load_any = mat_load || mat_inv_load;
  assign sel_mat  = dir_q ? mat_inv_q : mat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mat_inv_q <= MM_IDENTITY;
      dir_q     <= 1'b0;
    end else begin
      if (state_q == IDLE && mat_inv_load) mat_inv_q <= mat_inv_in;
      if (accept)                          dir_q     <= dir;
    end
  end
`else
  assign load_any = mat_load;
  assign sel_mat  = mat_q;
`endif

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = BUSY;
      BUSY:  if (beat_q == LAST_BEAT) state_d = (PIPE != 0) ? DRAIN : DONE;
      DRAIN: state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A matrix load wins over block acceptance in the same cycle.
  always_comb begin
    in_ready  = (state_q == IDLE) && !load_any;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // ---------------- matrix, capture and beat registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mat_q  <= MM_IDENTITY;
      beat_q <= '0;
    end else begin
      if (state_q == IDLE && mat_load) mat_q <= mat_in;
      if (accept)                      beat_q <= '0;
      else if (state_q == BUSY)        beat_q <= beat_q + 1'b1;
    end
  end

  // NOTE: the captured block is pure data, always written on acceptance
  // before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) in_q <= in_block;
  end

  // ---------------- lanes ----------------
  // Byte bit 7 feeds vector element 0; the output maps back the same way.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [7:0] slice, vec_in, vec_out;

    always_comb begin
      slice = in_q[8*(int'(beat_q)*LANES + k) +: 8];
      for (int b = 0; b < 8; b++) begin
        vec_in[b]   = slice[7-b];
        res_w[k][b] = vec_out[7-b];
      end
    end

    matrix_mul #(.D(1'b0)) u_mul (
      .m_i   (sel_mat),
      .in_i  (vec_in),
      .out_o (vec_out)
    );
  end

  // ---------------- write path ----------------
  if (PIPE != 0) begin : g_pipe
    logic [LANES-1:0][7:0] lane_q;
    logic [BW-1:0]         lane_beat_q;
    logic                  lane_vld_q;

    // Results from beat n land in the output register during beat n+1
    // (or DRAIN for the last beat).
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        lane_vld_q  <= 1'b0;
        lane_q      <= '0;
        lane_beat_q <= '0;
      end else begin
        lane_vld_q  <= (state_q == BUSY);
        lane_q      <= res_w;
        lane_beat_q <= beat_q;
      end
    end

    assign wr_en   = lane_vld_q;
    assign wr_beat = lane_beat_q;
    assign wr_data = lane_q;
  end else begin : g_comb
    assign wr_en   = (state_q == BUSY);
    assign wr_beat = beat_q;
    assign wr_data = res_w;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < LANES; k++) begin
        out_q[8*(int'(wr_beat)*LANES + k) +: 8] <= wr_data[k];
      end
    end
  end

  assign out_block = out_q;

endmodule : input_transform_stream

// File: tb/tb_input_transform_stream.sv
// Directed testbench for input_transform_stream (16 bytes, 4 lanes, PIPE=1).
// Define INPUT_TRANSFORM_STREAM_INV_EN to also exercise the inverse path.
module tb_input_transform_stream;
  import input_transform_stream_pkg::*;

  localparam int BB  = 16;
  localparam int W   = 8 * BB;
  localparam int LAT = 5;   // BLOCK_BYTES/LANES + PIPE

  localparam mm_matrix_t M_BITREV = 64'h0102_0408_1020_4080;
  localparam mm_matrix_t M_ZERO   = 64'h0;
  localparam mm_matrix_t M_L      = 64'hC060_3018_0C06_0301;
  localparam mm_matrix_t M_LINV   = 64'hFF7F_3F1F_0F07_0301;

  localparam logic [W-1:0] V_SEQ    = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [W-1:0] V_SEQ_BR = 128'h008844CC22AA66EE119955DD33BB77FF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mat_load;
  mm_matrix_t    mat_in;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_block;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_block;
  logic          busy;
`ifdef INPUT_TRANSFORM_STREAM_INV_EN
  logic          mat_inv_load;
  mm_matrix_t    mat_inv_in;
  logic          dir;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  input_transform_stream #(.BLOCK_BYTES(BB), .LANES(4), .PIPE(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mat_load     (mat_load),
    .mat_in       (mat_in),
`ifdef INPUT_TRANSFORM_STREAM_INV_EN
    .mat_inv_load (mat_inv_load),
    .mat_inv_in   (mat_inv_in),
    .dir          (dir),
`endif
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_block     (in_block),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_block    (out_block),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mat(input mm_matrix_t m);
    mat_load = 1'b1;
    mat_in   = m;
    tick();
    mat_load = 1'b0;
  endtask

  // Present a block and hold it until accepted (bounded).
  task automatic accept(input logic [W-1:0] blk);
    int n = 0;
    in_block = blk;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check("accept_timeout", W'(in_ready), W'(1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) check("out_timeout", W'(out_valid), W'(1));
  endtask

  // Full transaction with out_ready high; returns result and latency.
  task automatic run_block(input logic [W-1:0] blk, output logic [W-1:0] res,
                           output int lat);
    out_ready = 1'b1;
    accept(blk);
    wait_out(lat);
    res = out_block;
    tick();
  endtask

  initial begin
    logic [W-1:0] res;
    int lat;

    rst_n = 1'b0; mat_load = 1'b0; mat_in = '0; in_valid = 1'b0;
    in_block = '0; out_ready = 1'b1;
`ifdef INPUT_TRANSFORM_STREAM_INV_EN
    mat_inv_load = 1'b0; mat_inv_in = '0; dir = 1'b0;
`endif
    repeat (3) tick();
    check("rst_in_ready",  W'(in_ready),  W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_busy",      W'(busy),      W'(0));
    check("rst_out_block", out_block,     '0);
    rst_n = 1'b1;
    tick();

    // Identity pass-through and latency.
    run_block(V_SEQ, res, lat);
    check("ident_data", res, V_SEQ);
    check("ident_lat",  W'(lat), W'(LAT));
    check("ident_idle", W'(out_valid), W'(0));

    // Bit-reverse matrix.
    load_mat(M_BITREV);
    run_block({BB{8'h01}}, res, lat);
    check("brev_01", res, {BB{8'h80}});
    run_block({BB{8'h0F}}, res, lat);
    check("brev_0f", res, {BB{8'hF0}});
    run_block(V_SEQ, res, lat);
    check("brev_seq", res, V_SEQ_BR);
    check("brev_lat", W'(lat), W'(LAT));

    // Backpressure: hold DONE for 6 cycles with a second block pending.
    out_ready = 1'b0;
    accept({BB{8'h01}});
    wait_out(lat);
    check("bp_lat", W'(lat), W'(LAT));
    in_block = {BB{8'h0F}};
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("bp_valid",    W'(out_valid), W'(1));
      check("bp_data",     out_block,     {BB{8'h80}});
      check("bp_in_ready", W'(in_ready),  W'(0));
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", W'(out_valid), W'(0));
    check("bp_release_ready", W'(in_ready),  W'(1));
    tick();
    in_valid = 1'b0;
    check("bp_second_busy", W'(busy), W'(1));
    wait_out(lat);
    check("bp_second_lat",  W'(lat), W'(LAT));
    check("bp_second_data", out_block, {BB{8'hF0}});
    tick();

    // mat_load during BUSY is ignored for this and the next block.
    accept({BB{8'h01}});
    mat_load = 1'b1;
    mat_in   = M_ZERO;
    tick();
    mat_load = 1'b0;
    wait_out(lat);
    check("busy_load_cur", out_block, {BB{8'h80}});
    tick();
    run_block({BB{8'h01}}, res, lat);
    check("busy_load_next", res, {BB{8'h80}});

    // mat_load with in_valid in IDLE: load first, accept next cycle.
    mat_load = 1'b1;
    mat_in   = M_ZERO;
    in_block = {BB{8'hA5}};
    in_valid = 1'b1;
    #1;
    check("idle_load_ready0", W'(in_ready), W'(0));
    tick();
    mat_load = 1'b0;
    #1;
    check("idle_load_ready1", W'(in_ready), W'(1));
    tick();
    in_valid = 1'b0;
    check("idle_load_busy", W'(busy), W'(1));
    wait_out(lat);
    check("idle_load_data", out_block, '0);
    tick();

    // Reset at beat 2: everything back to reset values, matrix = identity.
    load_mat(M_BITREV);
    accept({BB{8'h01}});
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_valid", W'(out_valid), W'(0));
    check("midrst_busy",  W'(busy),      W'(0));
    check("midrst_ready", W'(in_ready),  W'(1));
    check("midrst_block", out_block,     '0);
    repeat (6) tick();
    check("midrst_still_idle", W'(out_valid), W'(0));
    run_block({BB{8'h01}}, res, lat);
    check("midrst_ident", res, {BB{8'h01}});
    check("midrst_lat",   W'(lat), W'(LAT));

`ifdef INPUT_TRANSFORM_STREAM_INV_EN
    mat_load = 1'b1;     mat_in     = M_L;
    mat_inv_load = 1'b1; mat_inv_in = M_LINV;
    #1;
    check("inv_load_ready0", W'(in_ready), W'(0));
    tick();
    mat_load = 1'b0; mat_inv_load = 1'b0;
    dir = 1'b0;
    run_block({BB{8'h80}}, res, lat);
    check("inv_fwd_80", res, {BB{8'hC0}});
    // dir is latched at acceptance; changing it mid-block must not matter.
    out_ready = 1'b1;
    dir = 1'b1;
    accept({BB{8'hC0}});
    dir = 1'b0;
    wait_out(lat);
    check("inv_back_c0", out_block, {BB{8'h80}});
    tick();
    dir = 1'b0;
    run_block(V_SEQ, res, lat);
    check("inv_fwd_differs", W'(res != V_SEQ), W'(1));
    dir = 1'b1;
    run_block(res, res, lat);
    dir = 1'b0;
    check("inv_roundtrip", res, V_SEQ);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_input_transform_stream
